hidden_delta_sequencer: RTL and testbench

HIDDEN_DELTA_SEQUENCER -- requirements
Module: hidden_delta_sequencer

---
 rtl/hidden_delta_sequencer_if.sv | 34 +++
 rtl/hidden_delta_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_hidden_delta_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hidden_delta_sequencer_if.sv
// hidden_delta_sequencer_if
// Groups the operand-write port, the start/busy handshake and the result
// stream of hidden_delta_sequencer.
//   master : drives writes and start, observes busy and results (testbench side)
//   slave  : the sequencer itself
// Signals:
//   wr_en, wr_sel[1:0], wr_k[1:0], wr_j[2:0], wr_data[W-1:0] - operand write
//   start, busy                                               - pass control
//   out_valid, out_idx[2:0], out_data[W-1:0], done            - result stream
interface hidden_delta_sequencer_if #(
   parameter int W = 10
);
   logic         wr_en;
   logic [1:0]   wr_sel;
   logic [1:0]   wr_k;
   logic [2:0]   wr_j;
   logic [W-1:0] wr_data;
   logic         start;
   logic         busy;
   logic         out_valid;
   logic [2:0]   out_idx;
   logic [W-1:0] out_data;
   logic         done;

   modport master (
      output wr_en, wr_sel, wr_k, wr_j, wr_data, start,
      input  busy, out_valid, out_idx, out_data, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_k, wr_j, wr_data, start,
      output busy, out_valid, out_idx, out_data, done
   );
endinterface

// File: rtl/hidden_delta_sequencer.sv
// hidden_delta_sequencer
// Back-propagates output-layer deltas to the hidden layer, one hidden neuron
// per step: delta0[j] = sat((sat(sum_k w[k][j]*delta1[k] >>> FRAC) * d) >>> FRAC)
// where d = out_cal[j]*(ONE-out_cal[j]) >>> FRAC is the sigmoid derivative.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - hidden_delta_sequencer_if.slave (operand writes, start/busy, results)
module hidden_delta_sequencer #(
   parameter int W     = 10,
   parameter int FRAC  = 6,
   parameter int N_HID = 5,
   parameter int N_OUT = 3
) (
   input logic                      clk,
   input logic                      rst,
   hidden_delta_sequencer_if.slave  bus
);

   localparam int ProdW = 2 * W;
   localparam int AccW  = 2 * W + 2;
   localparam int DerW  = 2 * W + 4;
   localparam int WideW = 3 * W + 4;
   localparam int One   = 1 << FRAC;

   localparam logic [1:0] KLast = 2'(N_OUT - 1);
   localparam logic [2:0] JLast = 3'(N_HID - 1);

   localparam logic signed [WideW-1:0] SatMax = WideW'((1 << (W - 1)) - 1);
   localparam logic signed [WideW-1:0] SatMin = WideW'(-(1 << (W - 1)));

   typedef enum logic [2:0] {StIdle, StMac, StScale, StEmit, StDone} state_e;

   state_e                  state_q, state_d;
   logic [2:0]              j_q, j_d;
   logic [1:0]              k_q, k_d;
   logic signed [AccW-1:0]  acc_q, acc_d;
   logic signed [W-1:0]     result_q, result_d;

   logic                    out_valid_q, done_q;
   logic [2:0]              out_idx_q;
   logic [W-1:0]            out_data_q;

   logic signed [W-1:0]     weight_q [N_OUT][N_HID];
   logic signed [W-1:0]     delta1_q [N_OUT];
   logic [W-1:0]            out_cal_q [N_HID];

   logic signed [ProdW-1:0] prod;
   logic signed [AccW-1:0]  acc_sh;
   logic signed [W-1:0]     s_sat;
   logic signed [W+1:0]     cal_ext, one_minus;
   logic signed [DerW-1:0]  der;
   logic signed [WideW-1:0] sd;

   function automatic logic signed [W-1:0] sat_w(input logic signed [WideW-1:0] v);
      if (v > SatMax) begin
         return SatMax[W-1:0];
      end else if (v < SatMin) begin
         return SatMin[W-1:0];
      end
      return v[W-1:0];
   endfunction

   // Datapath
   always_comb begin
      prod      = ProdW'(weight_q[k_q][j_q]) * ProdW'(delta1_q[k_q]);
      acc_sh    = acc_q >>> FRAC;
      s_sat     = sat_w(WideW'(acc_sh));
      // out_cal is unsigned; two extra bits keep ONE-out_cal representable
      cal_ext   = {2'b00, out_cal_q[j_q]};
      one_minus = (W + 2)'(One) - cal_ext;
      der       = (DerW'(cal_ext) * DerW'(one_minus)) >>> FRAC;
      sd        = WideW'(s_sat) * WideW'(der);
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      j_d      = j_q;
      k_d      = k_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StMac;
               j_d     = 3'd0;
               k_d     = 2'd0;
               acc_d   = '0;
            end
         end
         StMac: begin
            acc_d = acc_q + AccW'(prod);
            if (k_q == KLast) begin
               k_d     = 2'd0;
               state_d = StScale;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         StScale: begin
            result_d = sat_w(sd >>> FRAC);
            state_d  = StEmit;
         end
         StEmit: begin
            if (j_q != JLast) begin
               j_d     = j_q + 3'd1;
               acc_d   = '0;
               state_d = StMac;
            end else begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         j_q      <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         j_q      <= j_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   // Registered result stream; idx/data hold between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= (state_q == StEmit);
         done_q      <= (state_q == StDone);
         if (state_q == StEmit) begin
            out_idx_q  <= j_q;
            out_data_q <= result_q;
         end
      end
   end

   // Operand storage; writes only land while idle and in range
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) begin
            delta1_q[k] <= '0;
            for (int j = 0; j < N_HID; j++) begin
               weight_q[k][j] <= '0;
            end
         end
         for (int j = 0; j < N_HID; j++) begin
            out_cal_q[j] <= '0;
         end
      end else if (bus.wr_en && (state_q == StIdle)) begin
         case (bus.wr_sel)
            2'd0: begin
               if ((int'(bus.wr_k) < N_OUT) && (int'(bus.wr_j) < N_HID)) begin
                  weight_q[bus.wr_k][bus.wr_j] <= bus.wr_data;
               end
            end
            2'd1: begin
               if (int'(bus.wr_k) < N_OUT) begin
                  delta1_q[bus.wr_k] <= bus.wr_data;
               end
            end
            2'd2: begin
               if (int'(bus.wr_j) < N_HID) begin
                  out_cal_q[bus.wr_j] <= bus.wr_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_data  = out_data_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_hidden_delta_sequencer.sv
// tb_hidden_delta_sequencer
// Directed bench for hidden_delta_sequencer with hand-computed delta0 values.
// Nominal: acc=3*64*64=12288, s=192, d=32*32>>>6=16, delta0=192*16>>>6=48.
module tb_hidden_delta_sequencer;
   localparam int W = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hidden_delta_sequencer_if #(.W(W)) bus ();

   hidden_delta_sequencer #(
      .W    (W),
      .FRAC (6),
      .N_HID(5),
      .N_OUT(3)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [W-1:0] exp_d [5];
   logic [2:0]          last_idx;
   logic [W-1:0]        last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic write(input logic [1:0] sel, input logic [1:0] k, input logic [2:0] j,
                        input logic [W-1:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_k    = k;
      bus.wr_j    = j;
      bus.wr_data = data;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] wv, input logic [W-1:0] dv,
                       input logic [W-1:0] cv);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 5; j++) write(2'd0, 2'(k), 3'(j), wv);
         write(2'd1, 2'(k), 3'd0, dv);
      end
      for (int j = 0; j < 5; j++) write(2'd2, 2'd0, 3'(j), cv);
   endtask

   task automatic set_exp(input logic signed [W-1:0] v);
      for (int i = 0; i < 5; i++) exp_d[i] = v;
   endtask

   // Starts a pass (optionally with a same-cycle write) and checks every
   // output for the 26 cycles after start is accepted.
   task automatic run_pass(input string name, input bit disturb, input bit cw,
                           input logic [1:0] cs, input logic [2:0] cj,
                           input logic [W-1:0] cd);
      bit ev;
      int ej;
      bus.start = 1'b1;
      if (cw) begin
         bus.wr_en   = 1'b1;
         bus.wr_sel  = cs;
         bus.wr_k    = 2'd0;
         bus.wr_j    = cj;
         bus.wr_data = cd;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      for (int n = 1; n <= 26; n++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.wr_en = 1'b0;
         if (disturb && n == 3) begin
            // Attempts to zero weight[0][4] and restart; both must be dropped
            bus.start   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 2'd0;
            bus.wr_k    = 2'd0;
            bus.wr_j    = 3'd4;
            bus.wr_data = '0;
         end
         ev = (n >= 5) && (n <= 25) && (n % 5 == 0);
         ej = (n - 5) / 5;
         if (ev) begin
            last_idx  = 3'(ej);
            last_data = exp_d[ej];
         end
         check($sformatf("%s c%0d busy", name, n), 32'(bus.busy), 32'(n <= 25));
         check($sformatf("%s c%0d out_valid", name, n), 32'(bus.out_valid), 32'(ev));
         check($sformatf("%s c%0d done", name, n), 32'(bus.done), 32'(n == 26));
         check($sformatf("%s c%0d out_idx", name, n), 32'(bus.out_idx), 32'(last_idx));
         check($sformatf("%s c%0d out_data", name, n), 32'(bus.out_data), 32'(last_data));
      end
   endtask

   task automatic check_zero(input string name);
      check({name, " busy"}, 32'(bus.busy), 32'd0);
      check({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
      check({name, " done"}, 32'(bus.done), 32'd0);
      check({name, " out_idx"}, 32'(bus.out_idx), 32'd0);
      check({name, " out_data"}, 32'(bus.out_data), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 2'd0;
      bus.wr_k    = 2'd0;
      bus.wr_j    = 3'd0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      last_idx    = '0;
      last_data   = '0;
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Nominal
      load(10'sd64, 10'sd64, 10'd32);
      set_exp(10'sd48);
      run_pass("nominal", 1'b0, 1'b0, 2'd0, 3'd0, '0);

      // Negative weights
      load(10'b1111000000, 10'sd64, 10'd32);
      set_exp(-10'sd48);
      run_pass("negative", 1'b0, 1'b0, 2'd0, 3'd0, '0);

      // Saturation: acc=783363, s clamps to 511, 511*16>>>6=127
      load(10'sd511, 10'sd511, 10'd32);
      set_exp(10'sd127);
      run_pass("saturate", 1'b0, 1'b0, 2'd0, 3'd0, '0);

      // Derivative edges; out_cal[1]=64 written in the start cycle
      load(10'sd64, 10'sd64, 10'd32);
      write(2'd2, 2'd0, 3'd0, 10'd0);
      set_exp(10'sd48);
      exp_d[0] = '0;
      exp_d[1] = '0;
      run_pass("deriv", 1'b0, 1'b1, 2'd2, 3'd1, 10'd64);

      // Dropped writes: wr_sel=3, out-of-range k, then writes/start while busy
      write(2'd2, 2'd0, 3'd0, 10'd32);
      write(2'd2, 2'd0, 3'd1, 10'd32);
      write(2'd3, 2'd0, 3'd4, 10'd0);
      write(2'd0, 2'd3, 3'd4, 10'd0);
      set_exp(10'sd48);
      run_pass("busy_ign", 1'b1, 1'b0, 2'd0, 3'd0, '0);
      run_pass("after_busy", 1'b0, 1'b0, 2'd0, 3'd0, '0);

      // Reset mid-pass at T+8
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("pre_rst out_data", 32'(bus.out_data), 32'd48);
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst c%0d strobes", n), {30'd0, bus.out_valid, bus.done}, 32'd0);
      end
      last_idx  = '0;
      last_data = '0;
      // Storage was cleared by reset, so every result is 0
      set_exp('0);
      run_pass("cleared", 1'b0, 1'b0, 2'd0, 3'd0, '0);
      load(10'sd64, 10'sd64, 10'd32);
      set_exp(10'sd48);
      run_pass("reload", 1'b0, 1'b0, 2'd0, 3'd0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
